// File: rtl/oven_bake_controller_if.sv
// Front-panel / lamp side bundle of the oven bake controller.
// master: panel logic driving requests and reading status.
// slave:  the controller itself.
interface oven_bake_controller_if;
   logic        start;
   logic        cancel;
   logic [10:0] target_temp;
   logic [16:0] bake_time;
   logic [1:0]  state;
   logic        heater;
   logic        done;
   logic [10:0] temp;
   logic [16:0] remaining;
   logic        tick;

   modport master (
      output start, cancel, target_temp, bake_time,
      input  state, heater, done, temp, remaining, tick
   );

   modport slave (
      input  start, cancel, target_temp, bake_time,
      output state, heater, done, temp, remaining, tick
   );
endinterface

// File: rtl/oven_bake_controller.sv
// Oven bake sequencer: IDLE -> PREHEAT -> BAKE -> DONE with a 1 Hz
// prescaler, thermostat heater decode, bake countdown and a first-order
// oven temperature model.
// Optional feature macro: OVEN_AUTO_OFF_EN (DONE returns to IDLE after
// DONE_HOLD ticks). Without it DONE persists until cancel or restart.
module oven_bake_controller #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int AMBIENT   = 72,
   parameter int DONE_HOLD = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   oven_bake_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREHEAT = 2'd1,
      ST_BAKE    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int              CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [10:0]     AMB      = 11'(AMBIENT);
   localparam logic [10:0]     TEMP_MAX = 11'h7FF;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg;
   logic          start_q_reg;
   logic [10:0]   tgt_reg, tgt_next;
   logic [16:0]   bt_reg, bt_next;
   logic [10:0]   temp_reg;
   logic [16:0]   rem_reg, rem_next;
   logic          tick;
   logic          heater;
   logic          start_edge;
   logic          start_ok;

`ifdef OVEN_AUTO_OFF_EN
   localparam int            HW        = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);
   logic [HW-1:0] hold_reg, hold_next;
`endif

   assign tick       = (cnt_reg == CNT_LAST);
   assign start_edge = bus.start & ~start_q_reg;
   // A start edge only counts when there is something to bake.
   assign start_ok   = start_edge && (bus.bake_time != 17'd0);

   // 1 Hz prescaler, wraps at TICK_DIV-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else if (cnt_reg == CNT_LAST)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_reg + 1'b1;
   end

   // Heater decode: full power in preheat, thermostat in bake.
   always_comb begin
      heater = 1'b0;
      case (state_reg)
         ST_PREHEAT: heater = 1'b1;
         ST_BAKE:    heater = (temp_reg < tgt_reg);
         default:    heater = 1'b0;
      endcase
   end

   // Temperature model: one degree per tick, clamped to [AMBIENT, 2047].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         temp_reg <= AMB;
      else if (tick) begin
         if (heater) begin
            if (temp_reg != TEMP_MAX)
               temp_reg <= temp_reg + 11'd1;
         end else if (temp_reg > AMB) begin
            temp_reg <= temp_reg - 11'd1;
         end
      end
   end

   // State, latched settings, countdown and start edge detector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         start_q_reg <= 1'b0;
         tgt_reg     <= '0;
         bt_reg      <= '0;
         rem_reg     <= '0;
`ifdef OVEN_AUTO_OFF_EN
         hold_reg    <= '0;
`endif
      end else begin
         state_reg   <= state_next;
         start_q_reg <= bus.start;
         tgt_reg     <= tgt_next;
         bt_reg      <= bt_next;
         rem_reg     <= rem_next;
`ifdef OVEN_AUTO_OFF_EN
         hold_reg    <= hold_next;
`endif
      end
   end

   // Next-state logic; cancel overrides everything, including a start edge.
   always_comb begin
      state_next = state_reg;
      tgt_next   = tgt_reg;
      bt_next    = bt_reg;
      rem_next   = rem_reg;
`ifdef OVEN_AUTO_OFF_EN
      hold_next  = hold_reg;
`endif
      if (bus.cancel) begin
         state_next = ST_IDLE;
         rem_next   = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start_ok) begin
                  tgt_next   = bus.target_temp;
                  bt_next    = bus.bake_time;
                  state_next = ST_PREHEAT;
               end
            end
            ST_PREHEAT: begin
               if (temp_reg >= tgt_reg) begin
                  rem_next   = bt_reg;
                  state_next = ST_BAKE;
               end
            end
            ST_BAKE: begin
               if (tick) begin
                  if (rem_reg <= 17'd1) begin
                     rem_next   = '0;
                     state_next = ST_DONE;
`ifdef OVEN_AUTO_OFF_EN
                     hold_next  = '0;
`endif
                  end else begin
                     rem_next = rem_reg - 17'd1;
                  end
               end
            end
            ST_DONE: begin
               if (start_ok) begin
                  tgt_next   = bus.target_temp;
                  bt_next    = bus.bake_time;
                  state_next = ST_PREHEAT;
               end
`ifdef OVEN_AUTO_OFF_EN
               else if (tick) begin
                  if (hold_reg == HOLD_LAST)
                     state_next = ST_IDLE;
                  else
                     hold_next = hold_reg + 1'b1;
               end
`endif
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign bus.state     = state_reg;
   assign bus.heater    = heater;
   assign bus.done      = (state_reg == ST_DONE);
   assign bus.temp      = temp_reg;
   assign bus.remaining = rem_reg;
   assign bus.tick      = tick;

endmodule

// File: tb/tb_oven_bake_controller.sv
// Directed bench for oven_bake_controller with TICK_DIV=4, AMBIENT=72,
// DONE_HOLD=2. Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point.
module tb_oven_bake_controller;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   oven_bake_controller_if dut_if ();

   oven_bake_controller #(
      .TICK_DIV  (4),
      .AMBIENT   (72),
      .DONE_HOLD (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dut_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance through the edge that consumes the next tick.
   task automatic wait_tick();
      int n = 0;
      while (dut_if.tick !== 1'b1 && n < 20) begin
         step(1);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL wait_tick: no tick within 20 cycles");
      end
      step(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (dut_if.state !== 2'd0)      begin errors++; $display("FAIL rst_state: got %0d want 0", dut_if.state); end
      checks++; if (dut_if.temp !== 11'd72)     begin errors++; $display("FAIL rst_temp: got %0d want 72", dut_if.temp); end
      checks++; if (dut_if.remaining !== 17'd0) begin errors++; $display("FAIL rst_remaining: got %0d want 0", dut_if.remaining); end
      checks++; if (dut_if.heater !== 1'b0)     begin errors++; $display("FAIL rst_heater: got %0b want 0", dut_if.heater); end
      checks++; if (dut_if.done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %0b want 0", dut_if.done); end
      checks++; if (dut_if.tick !== 1'b0)       begin errors++; $display("FAIL rst_tick: got %0b want 0", dut_if.tick); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      // Tick is high in the cycle that ends at edges 4, 8, 12.
      for (int e = 1; e <= 12; e++) begin
         step(1);
         checks++;
         if (dut_if.tick !== ((e % 4) == 3))
            begin errors++; $display("FAIL tick_edge%0d: got %0b want %0b", e, dut_if.tick, ((e % 4) == 3)); end
      end
      $display("test_reset done");
   endtask

   task automatic test_full_bake();
      dut_if.target_temp = 11'd75;
      dut_if.bake_time   = 17'd3;
      dut_if.start       = 1'b1;   // kept high through DONE
      step(1);
      checks++; if (dut_if.state !== 2'd1) begin errors++; $display("FAIL fb_preheat: got %0d want 1", dut_if.state); end
      checks++; if (dut_if.heater !== 1'b1) begin errors++; $display("FAIL fb_heater_on: got %0b want 1", dut_if.heater); end
      for (int i = 1; i <= 3; i++) begin
         wait_tick();
         checks++; if (dut_if.temp !== 11'(72 + i)) begin errors++; $display("FAIL fb_temp%0d: got %0d want %0d", i, dut_if.temp, 72 + i); end
         checks++; if (dut_if.state !== 2'd1) begin errors++; $display("FAIL fb_still_preheat%0d: got %0d want 1", i, dut_if.state); end
      end
      step(1);
      checks++; if (dut_if.state !== 2'd2)      begin errors++; $display("FAIL fb_bake: got %0d want 2", dut_if.state); end
      checks++; if (dut_if.remaining !== 17'd3) begin errors++; $display("FAIL fb_rem3: got %0d want 3", dut_if.remaining); end
      checks++; if (dut_if.heater !== 1'b0)     begin errors++; $display("FAIL fb_heat75: got %0b want 0", dut_if.heater); end
      wait_tick();
      checks++; if (dut_if.remaining !== 17'd2) begin errors++; $display("FAIL fb_rem2: got %0d want 2", dut_if.remaining); end
      checks++; if (dut_if.temp !== 11'd74)     begin errors++; $display("FAIL fb_temp74: got %0d want 74", dut_if.temp); end
      checks++; if (dut_if.heater !== 1'b1)     begin errors++; $display("FAIL fb_heat74: got %0b want 1", dut_if.heater); end
      wait_tick();
      checks++; if (dut_if.remaining !== 17'd1) begin errors++; $display("FAIL fb_rem1: got %0d want 1", dut_if.remaining); end
      checks++; if (dut_if.temp !== 11'd75)     begin errors++; $display("FAIL fb_temp75b: got %0d want 75", dut_if.temp); end
      checks++; if (dut_if.heater !== 1'b0)     begin errors++; $display("FAIL fb_heat75b: got %0b want 0", dut_if.heater); end
      wait_tick();
      checks++; if (dut_if.remaining !== 17'd0) begin errors++; $display("FAIL fb_rem0: got %0d want 0", dut_if.remaining); end
      checks++; if (dut_if.state !== 2'd3)      begin errors++; $display("FAIL fb_done_state: got %0d want 3", dut_if.state); end
      checks++; if (dut_if.done !== 1'b1)       begin errors++; $display("FAIL fb_done: got %0b want 1", dut_if.done); end
      checks++; if (dut_if.heater !== 1'b0)     begin errors++; $display("FAIL fb_done_heater: got %0b want 0", dut_if.heater); end
      $display("test_full_bake done");
   endtask

   task automatic test_restart_from_done();
      step(3);   // start still held high
      checks++; if (dut_if.state !== 2'd3) begin errors++; $display("FAIL rs_held: got %0d want 3", dut_if.state); end
      dut_if.start = 1'b0;
      step(1);
      dut_if.bake_time = 17'd2;
      dut_if.start     = 1'b1;
      step(1);
      checks++; if (dut_if.state !== 2'd1)      begin errors++; $display("FAIL rs_preheat: got %0d want 1", dut_if.state); end
      checks++; if (dut_if.done !== 1'b0)       begin errors++; $display("FAIL rs_done_off: got %0b want 0", dut_if.done); end
      dut_if.start = 1'b0;
      step(1);
      dut_if.start  = 1'b1;
      dut_if.cancel = 1'b1;
      step(1);
      checks++; if (dut_if.state !== 2'd0)      begin errors++; $display("FAIL rs_cancel_wins: got %0d want 0", dut_if.state); end
      checks++; if (dut_if.remaining !== 17'd0) begin errors++; $display("FAIL rs_rem: got %0d want 0", dut_if.remaining); end
      dut_if.cancel = 1'b0;
      dut_if.start  = 1'b0;
      step(1);
      $display("test_restart_from_done done");
   endtask

   task automatic test_zero_bake();
      dut_if.target_temp = 11'd75;
      dut_if.bake_time   = 17'd0;
      dut_if.start       = 1'b1;
      step(2);
      checks++; if (dut_if.state !== 2'd0) begin errors++; $display("FAIL zb_ignored: got %0d want 0", dut_if.state); end
      dut_if.start = 1'b0;
      step(1);
      dut_if.target_temp = 11'd70;
      dut_if.bake_time   = 17'd2;
      dut_if.start       = 1'b1;
      step(1);
      checks++; if (dut_if.state !== 2'd1) begin errors++; $display("FAIL zb_preheat: got %0d want 1", dut_if.state); end
      step(1);
      checks++; if (dut_if.state !== 2'd2)      begin errors++; $display("FAIL zb_bake: got %0d want 2", dut_if.state); end
      checks++; if (dut_if.remaining !== 17'd2) begin errors++; $display("FAIL zb_rem: got %0d want 2", dut_if.remaining); end
      checks++; if (dut_if.heater !== 1'b0)     begin errors++; $display("FAIL zb_heater: got %0b want 0", dut_if.heater); end
      dut_if.start  = 1'b0;
      dut_if.cancel = 1'b1;
      step(1);
      dut_if.cancel = 1'b0;
      $display("test_zero_bake done");
   endtask

   task automatic test_cancel();
      int n;
      n = 0;
      while (dut_if.temp !== 11'd72 && n < 10) begin wait_tick(); n++; end
      dut_if.target_temp = 11'd75;
      dut_if.bake_time   = 17'd5;
      dut_if.start       = 1'b1;
      step(1);
      dut_if.start = 1'b0;
      n = 0;
      while (dut_if.state !== 2'd2 && n < 40) begin step(1); n++; end
      checks++; if (dut_if.remaining !== 17'd5) begin errors++; $display("FAIL cn_rem5: got %0d want 5", dut_if.remaining); end
      checks++; if (dut_if.temp !== 11'd75)     begin errors++; $display("FAIL cn_temp75: got %0d want 75", dut_if.temp); end
      dut_if.cancel = 1'b1;
      step(1);
      dut_if.cancel = 1'b0;
      checks++; if (dut_if.state !== 2'd0)      begin errors++; $display("FAIL cn_idle: got %0d want 0", dut_if.state); end
      checks++; if (dut_if.remaining !== 17'd0) begin errors++; $display("FAIL cn_rem0: got %0d want 0", dut_if.remaining); end
      for (int i = 1; i <= 5; i++) begin
         wait_tick();
         checks++;
         if (dut_if.temp !== 11'((75 - i) < 72 ? 72 : (75 - i)))
            begin errors++; $display("FAIL cn_decay%0d: got %0d want %0d", i, dut_if.temp, ((75 - i) < 72 ? 72 : (75 - i))); end
      end
      $display("test_cancel done");
   endtask

   task automatic test_auto_off();
      dut_if.target_temp = 11'd70;
      dut_if.bake_time   = 17'd1;
      dut_if.start       = 1'b1;
      step(1);
      dut_if.start = 1'b0;
      step(1);
      checks++; if (dut_if.remaining !== 17'd1) begin errors++; $display("FAIL ao_rem1: got %0d want 1", dut_if.remaining); end
      wait_tick();
      checks++; if (dut_if.state !== 2'd3) begin errors++; $display("FAIL ao_done: got %0d want 3", dut_if.state); end
`ifdef OVEN_AUTO_OFF_EN
      wait_tick();
      checks++; if (dut_if.state !== 2'd3) begin errors++; $display("FAIL ao_hold1: got %0d want 3", dut_if.state); end
      wait_tick();
      checks++; if (dut_if.state !== 2'd0) begin errors++; $display("FAIL ao_off: got %0d want 0", dut_if.state); end
      checks++; if (dut_if.done !== 1'b0)  begin errors++; $display("FAIL ao_done_off: got %0b want 0", dut_if.done); end
`else
      repeat (100) wait_tick();
      checks++; if (dut_if.state !== 2'd3) begin errors++; $display("FAIL ao_persist: got %0d want 3", dut_if.state); end
      checks++; if (dut_if.done !== 1'b1)  begin errors++; $display("FAIL ao_done_on: got %0b want 1", dut_if.done); end
`endif
      $display("test_auto_off done");
   endtask

   task automatic test_reset_mid_bake();
      int n;
      n = 0;
      while (dut_if.temp !== 11'd72 && n < 10) begin wait_tick(); n++; end
      dut_if.target_temp = 11'd75;
      dut_if.bake_time   = 17'd5;
      dut_if.start       = 1'b1;
      step(1);
      dut_if.start = 1'b0;
      n = 0;
      while (dut_if.state !== 2'd2 && n < 40) begin step(1); n++; end
      checks++; if (dut_if.state !== 2'd2) begin errors++; $display("FAIL rm_in_bake: got %0d want 2", dut_if.state); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (dut_if.state !== 2'd0)      begin errors++; $display("FAIL rm_state: got %0d want 0", dut_if.state); end
      checks++; if (dut_if.temp !== 11'd72)     begin errors++; $display("FAIL rm_temp: got %0d want 72", dut_if.temp); end
      checks++; if (dut_if.remaining !== 17'd0) begin errors++; $display("FAIL rm_rem: got %0d want 0", dut_if.remaining); end
      checks++; if (dut_if.heater !== 1'b0)     begin errors++; $display("FAIL rm_heater: got %0b want 0", dut_if.heater); end
      checks++; if (dut_if.tick !== 1'b0)       begin errors++; $display("FAIL rm_tick: got %0b want 0", dut_if.tick); end
      @(negedge clk) rst_n = 1'b1;
      step(1);
      checks++; if (dut_if.state !== 2'd0) begin errors++; $display("FAIL rm_after: got %0d want 0", dut_if.state); end
      $display("test_reset_mid_bake done");
   endtask

   initial begin
      errors = 0;
      checks = 0;
      dut_if.start       = 1'b0;
      dut_if.cancel      = 1'b0;
      dut_if.target_temp = 11'd0;
      dut_if.bake_time   = 17'd0;
      test_reset();
      test_full_bake();
      test_restart_from_done();
      test_zero_bake();
      test_cancel();
      test_auto_off();
      test_reset_mid_bake();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
